// File: rtl/krnl_ctrl_sequencer.sv
// Kernel invocation sequencer: latches pointers on ap_start, launches read DMA,
// kernel pipeline and write DMA together, gathers their completions, reports ap_done.
module krnl_ctrl_sequencer #(
    parameter int unsigned C_ADDR_WIDTH = 64,
    parameter int unsigned C_LEN_WIDTH  = 32,
    parameter int unsigned C_TIMEOUT    = 0
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    aclk_en,
    input  logic                    ap_start,
    output logic                    ap_idle,
    output logic                    ap_done,
    input  logic [C_ADDR_WIDTH-1:0] src_ptr,
    input  logic [C_ADDR_WIDTH-1:0] dst_ptr,
    input  logic [C_LEN_WIDTH-1:0]  xfer_len,
    output logic                    rd_start,
    output logic [C_ADDR_WIDTH-1:0] rd_addr,
    output logic [C_LEN_WIDTH-1:0]  rd_len,
    input  logic                    rd_done,
    output logic                    krnl_start,
    input  logic                    krnl_done,
    output logic                    wr_start,
    output logic [C_ADDR_WIDTH-1:0] wr_addr,
    output logic [C_LEN_WIDTH-1:0]  wr_len,
    input  logic                    wr_done,
    output logic [31:0]             run_cycles,
    output logic                    timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_DONE} state_t;

    state_t      state_reg;
    logic        rd_flag_reg;
    logic        krnl_flag_reg;
    logic        wr_flag_reg;
    logic [31:0] cnt_reg;
    logic [31:0] cnt_next;
    logic        all_done;
    logic        wd_hit;

    // Saturating increment; the watchdog compares against the post-increment value
    // so the run ends on the edge where the counter would read C_TIMEOUT.
    assign cnt_next = (cnt_reg == 32'hFFFF_FFFF) ? cnt_reg : cnt_reg + 32'd1;
    assign all_done = (rd_flag_reg | rd_done) & (krnl_flag_reg | krnl_done) &
                      (wr_flag_reg | wr_done);
    assign wd_hit   = (C_TIMEOUT != 0) && (cnt_next >= C_TIMEOUT);

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg     <= S_IDLE;
            rd_flag_reg   <= 1'b0;
            krnl_flag_reg <= 1'b0;
            wr_flag_reg   <= 1'b0;
            cnt_reg       <= '0;
            ap_idle       <= 1'b1;
            ap_done       <= 1'b0;
            rd_start      <= 1'b0;
            krnl_start    <= 1'b0;
            wr_start      <= 1'b0;
            rd_addr       <= '0;
            wr_addr       <= '0;
            rd_len        <= '0;
            wr_len        <= '0;
            run_cycles    <= '0;
            timeout_err   <= 1'b0;
        end else if (aclk_en) begin
            case (state_reg)
                S_IDLE: begin
                    if (ap_start) begin
                        rd_addr       <= src_ptr;
                        wr_addr       <= dst_ptr;
                        rd_len        <= xfer_len;
                        wr_len        <= xfer_len;
                        rd_flag_reg   <= 1'b0;
                        krnl_flag_reg <= 1'b0;
                        wr_flag_reg   <= 1'b0;
                        cnt_reg       <= '0;
                        timeout_err   <= 1'b0;
                        ap_idle       <= 1'b0;
                        rd_start      <= 1'b1;
                        krnl_start    <= 1'b1;
                        wr_start      <= 1'b1;
                        state_reg     <= S_LAUNCH;
                    end
                end
                // Done inputs are not sampled here: no engine can finish this early.
                S_LAUNCH: begin
                    rd_start   <= 1'b0;
                    krnl_start <= 1'b0;
                    wr_start   <= 1'b0;
                    cnt_reg    <= cnt_next;
                    state_reg  <= S_RUN;
                end
                S_RUN: begin
                    cnt_reg       <= cnt_next;
                    rd_flag_reg   <= rd_flag_reg | rd_done;
                    krnl_flag_reg <= krnl_flag_reg | krnl_done;
                    wr_flag_reg   <= wr_flag_reg | wr_done;
                    // A completion landing on the watchdog edge counts as a clean finish.
                    if (all_done || wd_hit) begin
                        run_cycles  <= cnt_next;
                        timeout_err <= ~all_done;
                        ap_done     <= 1'b1;
                        state_reg   <= S_DONE;
                    end
                end
                S_DONE: begin
                    ap_done   <= 1'b0;
                    ap_idle   <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: begin
                    ap_done   <= 1'b0;
                    ap_idle   <= 1'b1;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_krnl_ctrl_sequencer.sv
// Self-checking bench for krnl_ctrl_sequencer: vector table, randomized runs
// against an offset-based completion model, and reset / enable corner cases.
module tb_krnl_ctrl_sequencer;

    localparam int C_TO = 20;

    logic        aclk = 1'b0;
    logic        areset;
    logic        aclk_en;
    logic        ap_start;
    logic        ap_idle;
    logic        ap_done;
    logic [63:0] src_ptr;
    logic [63:0] dst_ptr;
    logic [31:0] xfer_len;
    logic        rd_start;
    logic [63:0] rd_addr;
    logic [31:0] rd_len;
    logic        rd_done;
    logic        krnl_start;
    logic        krnl_done;
    logic        wr_start;
    logic [63:0] wr_addr;
    logic [31:0] wr_len;
    logic        wr_done;
    logic [31:0] run_cycles;
    logic        timeout_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 aclk = ~aclk;

    krnl_ctrl_sequencer #(
        .C_ADDR_WIDTH(64),
        .C_LEN_WIDTH (32),
        .C_TIMEOUT   (C_TO)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .aclk_en    (aclk_en),
        .ap_start   (ap_start),
        .ap_idle    (ap_idle),
        .ap_done    (ap_done),
        .src_ptr    (src_ptr),
        .dst_ptr    (dst_ptr),
        .xfer_len   (xfer_len),
        .rd_start   (rd_start),
        .rd_addr    (rd_addr),
        .rd_len     (rd_len),
        .rd_done    (rd_done),
        .krnl_start (krnl_start),
        .krnl_done  (krnl_done),
        .wr_start   (wr_start),
        .wr_addr    (wr_addr),
        .wr_len     (wr_len),
        .wr_done    (wr_done),
        .run_cycles (run_cycles),
        .timeout_err(timeout_err)
    );

    // Each mask bit k means that engine pulses done on the k-th enabled edge after acceptance.
    typedef struct {
        string       name;
        logic [63:0] src;
        logic [63:0] dst;
        logic [31:0] len;
        logic [31:0] rd_m;
        logic [31:0] kr_m;
        logic [31:0] wr_m;
        int          en_lo_at;
        int          exp_rc;
        bit          exp_to;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic int first_valid(input logic [31:0] m);
        for (int i = 2; i < 32; i++) if (m[i]) return i;
        return 1000;
    endfunction

    // Run ends when the latest engine has reported; the watchdog caps it at C_TO.
    task automatic model(input logic [31:0] rm, km, wm, output int rc, output bit to);
        int a, b, c, fin;
        a = first_valid(rm);
        b = first_valid(km);
        c = first_valid(wm);
        fin = (a > b) ? a : b;
        fin = (fin > c) ? fin : c;
        if (fin > C_TO) begin rc = C_TO; to = 1'b1; end
        else begin rc = fin; to = 1'b0; end
    endtask

    task automatic run(input vec_t v);
        int  e;
        int  ndone;
        bit  prev;
        bit  en;
        int  idx;
        int  fails0;
        fails0 = total_cnt - pass_cnt;
        @(negedge aclk);
        src_ptr = v.src; dst_ptr = v.dst; xfer_len = v.len;
        rd_done = 0; krnl_done = 0; wr_done = 0; aclk_en = 1; ap_start = 1;
        @(posedge aclk);
        @(negedge aclk);
        src_ptr = ~v.src; dst_ptr = ~v.dst; xfer_len = ~v.len;
        chk({v.name, " launch pulses"}, {rd_start, krnl_start, wr_start}, 3'b111);
        chk({v.name, " idle low"}, ap_idle, 0);
        chk({v.name, " rd_addr"}, rd_addr, v.src);
        chk({v.name, " wr_addr"}, wr_addr, v.dst);
        e = 0; ndone = 0; prev = 0;
        for (int t = 1; t <= 45; t++) begin
            en = !(v.en_lo_at > 0 && t > v.en_lo_at && t <= v.en_lo_at + 4);
            aclk_en = en;
            idx = e + 1;
            if (en) begin
                rd_done   = (idx < 32) ? v.rd_m[idx] : 1'b0;
                krnl_done = (idx < 32) ? v.kr_m[idx] : 1'b0;
                wr_done   = (idx < 32) ? v.wr_m[idx] : 1'b0;
            end else begin
                rd_done = 1; krnl_done = 1; wr_done = 1;
            end
            @(posedge aclk);
            if (en) e++;
            @(negedge aclk);
            chk({v.name, " ap_done"}, ap_done, (e == v.exp_rc));
            chk({v.name, " ap_idle"}, ap_idle, (e > v.exp_rc));
            chk({v.name, " no start"}, {rd_start, krnl_start, wr_start}, 3'b000);
            if (ap_done && !prev) ndone++;
            prev = ap_done;
            if (ap_done) ap_start = 0;
        end
        aclk_en = 1; rd_done = 0; krnl_done = 0; wr_done = 0; ap_start = 0;
        chk({v.name, " done count"}, ndone, 1);
        chk({v.name, " run_cycles"}, run_cycles, v.exp_rc);
        chk({v.name, " timeout_err"}, timeout_err, v.exp_to);
        chk({v.name, " rd_len"}, rd_len, v.len);
        chk({v.name, " wr_len"}, wr_len, v.len);
        chk({v.name, " rd_addr hold"}, rd_addr, v.src);
        chk({v.name, " wr_addr hold"}, wr_addr, v.dst);
        $display("run %-10s rc=%0d to=%0d dones=%0d %s", v.name, run_cycles, timeout_err,
                 ndone, ((total_cnt - pass_cnt) == fails0) ? "ok" : "bad");
    endtask

    vec_t tbl[9];
    vec_t rv;

    initial begin
        tbl[0] = '{"basic",   64'h1000, 64'h8000, 32'd4096, 32'h1<<5, 32'h1<<7, 32'h1<<12, 0, 12, 0};
        tbl[1] = '{"same",    64'h2000, 64'h9000, 32'd64,   32'h1<<3, 32'h1<<3, 32'h1<<3,  0, 3,  0};
        tbl[2] = '{"reverse", 64'h3000, 64'hA000, 32'd128,  32'h240,  32'h1<<5, 32'h1<<3,  0, 6,  0};
        tbl[3] = '{"timeout", 64'h4000, 64'hB000, 32'd256,  32'h1<<4, 32'h1<<6, 32'h0,     0, 20, 1};
        tbl[4] = '{"recover", 64'h5000, 64'hC000, 32'd512,  32'h1<<2, 32'h1<<2, 32'h1<<2,  0, 2,  0};
        tbl[5] = '{"len0",    64'hDEAD_BEEF_0000_1000, 64'hCAFE_0000_2000, 32'd0,
                   32'h1<<2, 32'h1<<2, 32'h1<<2, 0, 2, 0};
        tbl[6] = '{"launchdn", 64'h6000, 64'hD000, 32'd8,   32'h12,   32'h22,   32'hA,     0, 5,  0};
        tbl[7] = '{"enable",  64'h7000, 64'hE000, 32'd16,   32'h1<<3, 32'h1<<6, 32'h1<<8,  5, 8,  0};
        tbl[8] = '{"edge20",  64'h7100, 64'hE100, 32'd32,   32'h1<<20, 32'h1<<2, 32'h1<<9, 0, 20, 0};

        areset = 1; aclk_en = 1; ap_start = 0; src_ptr = 0; dst_ptr = 0; xfer_len = 0;
        rd_done = 0; krnl_done = 0; wr_done = 0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        areset = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            chk("rst idle", ap_idle, 1);
            chk("rst done", ap_done, 0);
            chk("rst starts", {rd_start, krnl_start, wr_start}, 3'b000);
            chk("rst run_cycles", run_cycles, 0);
        end
        chk("rst timeout", timeout_err, 0);
        chk("rst rd_addr", rd_addr, 0);
        chk("rst wr_len", wr_len, 0);
        $display("run reset      idle checks done");

        foreach (tbl[i]) run(tbl[i]);

        for (int r = 0; r < 30; r++) begin
            rv.name = $sformatf("rand%0d", r);
            rv.src  = {$urandom, $urandom};
            rv.dst  = {$urandom, $urandom};
            rv.len  = $urandom;
            rv.rd_m = ($urandom_range(0, 9) == 0) ? 32'h0 : ($urandom & $urandom & 32'h00FF_FFFE);
            rv.kr_m = $urandom & $urandom & 32'h00FF_FFFE;
            rv.wr_m = $urandom & $urandom & 32'h00FF_FFFE;
            rv.en_lo_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 15)) : 0;
            model(rv.rd_m, rv.kr_m, rv.wr_m, rv.exp_rc, rv.exp_to);
            run(rv);
        end

        // Reset in the middle of RUN after one completion was captured.
        @(negedge aclk);
        src_ptr = 64'h1234; dst_ptr = 64'h5678; xfer_len = 32'd99; ap_start = 1;
        for (int t = 0; t < 5; t++) begin
            rd_done = (t == 3);
            @(posedge aclk);
            @(negedge aclk);
        end
        rd_done = 0; areset = 1;
        @(posedge aclk);
        @(negedge aclk);
        areset = 0; ap_start = 0;
        chk("midrst idle", ap_idle, 1);
        chk("midrst done", ap_done, 0);
        chk("midrst rd_addr", rd_addr, 0);
        chk("midrst wr_addr", wr_addr, 0);
        chk("midrst rd_len", rd_len, 0);
        chk("midrst run_cycles", run_cycles, 0);
        chk("midrst timeout", timeout_err, 0);
        for (int t = 0; t < 25; t++) begin
            krnl_done = 1; wr_done = 1;
            @(negedge aclk);
            chk("midrst no done", ap_done, 0);
            chk("midrst stays idle", ap_idle, 1);
        end
        krnl_done = 0; wr_done = 0;
        $display("run midreset   abort checked");
        run(tbl[1]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/krnl_ctrl_sequencer.md
Name: krnl_ctrl_sequencer

Overview:
- Sequences one kernel invocation between the AXI4-Lite control slave and the datapath engines.
- On ap_start it latches the source/destination pointers and length, then launches the read DMA, the kernel pipeline and the write DMA.
- It collects their completions in any order, then returns ap_done/ap_idle to the control slave.
- It also measures run cycles and enforces an optional watchdog.

Parameters:
- C_ADDR_WIDTH, 64, pointer width.
- C_LEN_WIDTH, 32, transfer length width (bytes).
- C_TIMEOUT, 0, watchdog limit in RUN cycles; 0 disables the watchdog.

Ports:
- aclk  in  1  clock
- areset  in  1  reset, synchronous, active-high
- aclk_en  in  1  clock enable; when low all state, counters and outputs hold
- ap_start  in  1  level from control slave, held until ap_done
- ap_idle  out  1  high when sequencer is in IDLE
- ap_done  out  1  one-cycle completion pulse
- src_ptr  in  C_ADDR_WIDTH  read base address
- dst_ptr  in  C_ADDR_WIDTH  write base address
- xfer_len  in  C_LEN_WIDTH  bytes to move
- rd_start  out  1  one-cycle launch pulse to read DMA
- rd_addr  out  C_ADDR_WIDTH  latched src_ptr
- rd_len  out  C_LEN_WIDTH  latched xfer_len
- rd_done  in  1  read DMA completion pulse
- krnl_start  out  1  one-cycle launch pulse to kernel pipeline
- krnl_done  in  1  kernel completion pulse
- wr_start  out  1  one-cycle launch pulse to write DMA
- wr_addr  out  C_ADDR_WIDTH  latched dst_ptr
- wr_len  out  C_LEN_WIDTH  latched xfer_len
- wr_done  in  1  write DMA completion pulse
- run_cycles  out  32  cycles of the last run, saturating
- timeout_err  out  1  sticky; last run ended by watchdog

Behaviour:
- All outputs are registered. All updates are gated by aclk_en except reset.
- States: IDLE, LAUNCH, RUN, DONE.
- Reset: state IDLE; ap_idle=1; all other outputs 0; rd_addr/wr_addr/lengths 0; run_cycles 0; timeout_err 0; done flags cleared. Reset mid-run aborts without emitting ap_done.
- IDLE: ap_idle=1. If ap_start=1 at edge N:
  - latch src_ptr, dst_ptr, xfer_len;
  - clear done flags and the cycle counter; clear timeout_err;
  - go to LAUNCH. ap_idle falls at N+1.
- LAUNCH (exactly 1 cycle): rd_start, krnl_start and wr_start are high together for this single cycle, then RUN unconditionally.
  - Done inputs arriving in LAUNCH are ignored; engines cannot complete within one cycle of start.
- RUN:
  - rd_done, krnl_done and wr_done are each captured into a sticky flag.
  - Any order is allowed, including simultaneous arrival.
  - Completion test is (flag | input) for all three, so a final done transitions on that same edge to DONE.
  - Repeated done pulses are harmless.
- Cycle counter: increments each enabled cycle in LAUNCH and RUN, saturates at 0xFFFFFFFF, and is copied to run_cycles on entering DONE.
- Watchdog: if C_TIMEOUT>0 and the counter reaches C_TIMEOUT while in RUN with flags incomplete, set timeout_err=1 and go to DONE.
- DONE (exactly 1 cycle): ap_done=1, then IDLE. Because the control slave drops ap_start on the ap_done edge, IDLE sees ap_start=0 and does not relaunch.
  - If ap_start is still high in IDLE, a new run starts; this is a legal back-to-back run.
- ap_start changes outside IDLE are ignored.
- Latched addresses and lengths stay stable from LAUNCH until the next acceptance.
- Latency from ap_start acceptance (edge N):
  - start pulses at cycle N+1;
  - ap_done asserted 1 cycle after the edge on which the last done is seen.
- xfer_len=0 is still launched; the engines are responsible for reporting done immediately.

Test Plan:
- Reset, then idle 10 cycles -> ap_idle=1; ap_done, all start pulses and run_cycles = 0.
- ap_start with src=0x1000, dst=0x8000, len=4096; rd_done@+5, krnl_done@+7, wr_done@+12 -> start pulses 1 cycle, rd_addr=0x1000, wr_addr=0x8000, rd_len=wr_len=4096; one ap_done pulse; run_cycles=12; ap_idle restored.
- All three dones in the same cycle at +3 -> ap_done the cycle after; run_cycles=3; no duplicate pulse.
- Dones in reverse order (wr, krnl, rd) plus a duplicate rd_done -> exactly one ap_done.
- C_TIMEOUT=20 with wr_done never arriving -> timeout_err=1, ap_done pulses at RUN cycle 20, then IDLE. The next clean run clears timeout_err.
- areset asserted in RUN, and aclk_en low for 4 cycles mid-RUN:
  - reset case -> IDLE, no ap_done, outputs at reset values;
  - enable case -> state and counter frozen, run_cycles excludes the 4 disabled cycles.
